rrat: RTL and testbench

- Retirement register alias table: the architectural (committed) arch-reg -> PRF map.
- Sits at the ROB commit port and feeds the rename RAT.
- Consumes up to N retiring destination mappings per cycle.
- Produces the committed map and the committed free list, which the RAT reloads on nuke.
- Produces a per-cycle vector of PRF entries released by commit, which the RAT and PRF use to free entries.

---
 rtl/rrat_pkg.sv | 25 ++
 rtl/rrat.sv | 95 +++++++++
 tb/tb_rrat.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/rrat_pkg.sv
// rrat_pkg: shared sizing constants and the retire packet type used by the
// ROB commit port and the retirement register alias table.
//
// Contents:
//   N                   retire width (slots per cycle, slot 0 oldest)
//   RAT_SIZE            number of architectural registers
//   PRF_NUM_ENTRIES     number of physical registers
//   PRF_NUM_INDEX_BITS  physical register index width
//   REG_INDEX_BITS      architectural register index width
//   retire_packet_t     {valid, arch_dest, phys_dest} for one retiring slot
package rrat_pkg;

   localparam int N                  = 3;
   localparam int RAT_SIZE           = 32;
   localparam int PRF_NUM_ENTRIES    = 64;
   localparam int PRF_NUM_INDEX_BITS = 6;
   localparam int REG_INDEX_BITS     = 5;

   typedef struct packed {
      logic                          valid;
      logic [REG_INDEX_BITS-1:0]     arch_dest;
      logic [PRF_NUM_INDEX_BITS-1:0] phys_dest;
   } retire_packet_t;

endpackage

// File: rtl/rrat.sv
// rrat: retirement register alias table. Holds the committed
// arch-reg -> PRF map and the committed free list, and reports which PRF
// entries were released by each cycle's commits.
//
// Ports:
//   clock                  single clock, all state on posedge
//   reset                  synchronous, active-high; wins over retires
//   retire_valid           [N]    slot i retires a dest-writing instruction
//   retire_arch_dest       [N][5] arch dest of slot i
//   retire_phys_dest       [N][6] PRF entry assigned to slot i at rename
//   rrat_entries           [32][6] committed map (registered)
//   rrat_free_list         [64]   1 = entry not committed-live (registered)
//   free_vector_from_rrat  [64]   entries released by last cycle's commits
//   commit_error           sticky: a live PRF entry was committed again
//
// Interface: the retire port has no ready; every valid slot presented in a
// cycle is consumed in that cycle. Slot 0 is the oldest.
module rrat
   import rrat_pkg::*;
(
   input  logic                                              clock,
   input  logic                                              reset,
   input  logic [N-1:0]                                      retire_valid,
   input  logic [N-1:0][REG_INDEX_BITS-1:0]                  retire_arch_dest,
   input  logic [N-1:0][PRF_NUM_INDEX_BITS-1:0]              retire_phys_dest,
   output logic [RAT_SIZE-1:0][PRF_NUM_INDEX_BITS-1:0]       rrat_entries,
   output logic [PRF_NUM_ENTRIES-1:0]                        rrat_free_list,
   output logic [PRF_NUM_ENTRIES-1:0]                        free_vector_from_rrat,
   output logic                                              commit_error
);

   retire_packet_t [N-1:0]                        pkt;
   logic [RAT_SIZE-1:0][PRF_NUM_INDEX_BITS-1:0]   run_map;
   logic [PRF_NUM_ENTRIES-1:0]                    run_free;
   logic [PRF_NUM_ENTRIES-1:0]                    run_release;
   // Entries made live by an earlier slot of this same cycle and not since
   // released; a second claim of one of these is a double commit.
   logic [PRF_NUM_ENTRIES-1:0]                    claimed_now;
   logic [PRF_NUM_INDEX_BITS-1:0]                 old_phys;
   logic                                          err_now;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         pkt[i].valid     = retire_valid[i];
         pkt[i].arch_dest = retire_arch_dest[i];
         pkt[i].phys_dest = retire_phys_dest[i];
      end
   end

   // Walk the slots oldest to youngest so a younger slot to the same arch
   // sees the older slot's phys as its "old" mapping.
   always_comb begin
      run_map     = rrat_entries;
      run_free    = rrat_free_list;
      run_release = '0;
      claimed_now = '0;
      old_phys    = '0;
      err_now     = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (pkt[i].valid && (pkt[i].arch_dest != '0)) begin
            old_phys = run_map[pkt[i].arch_dest];
            if (!rrat_free_list[pkt[i].phys_dest] || claimed_now[pkt[i].phys_dest])
               err_now = 1'b1;
            run_map[pkt[i].arch_dest]     = pkt[i].phys_dest;
            run_free[pkt[i].phys_dest]    = 1'b0;
            // Last writer wins: an entry released earlier this cycle and
            // reused here ends live and is not reported as released.
            run_release[pkt[i].phys_dest] = 1'b0;
            claimed_now[pkt[i].phys_dest] = 1'b1;
            if ((old_phys != '0) && (old_phys != pkt[i].phys_dest)) begin
               run_release[old_phys] = 1'b1;
               run_free[old_phys]    = 1'b1;
               claimed_now[old_phys] = 1'b0;
            end
         end
      end
      // PRF 0 is the reset mapping and is never handed back.
      run_release[0] = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rrat_entries          <= '0;
         rrat_free_list        <= '1;
         free_vector_from_rrat <= '0;
         commit_error          <= 1'b0;
      end else begin
         rrat_entries          <= run_map;
         rrat_free_list        <= run_free;
         free_vector_from_rrat <= run_release;
         commit_error          <= commit_error | err_now;
      end
   end

endmodule

// File: tb/tb_rrat.sv
// tb_rrat: directed-vector bench for rrat with hand-computed expectations.
module tb_rrat;
   import rrat_pkg::*;

   logic                                          clock;
   logic                                          reset;
   logic [N-1:0]                                  retire_valid;
   logic [N-1:0][REG_INDEX_BITS-1:0]              retire_arch_dest;
   logic [N-1:0][PRF_NUM_INDEX_BITS-1:0]          retire_phys_dest;
   logic [RAT_SIZE-1:0][PRF_NUM_INDEX_BITS-1:0]   rrat_entries;
   logic [PRF_NUM_ENTRIES-1:0]                    rrat_free_list;
   logic [PRF_NUM_ENTRIES-1:0]                    free_vector_from_rrat;
   logic                                          commit_error;

   int checks;
   int failures;

   rrat dut (
      .clock                 (clock),
      .reset                 (reset),
      .retire_valid          (retire_valid),
      .retire_arch_dest      (retire_arch_dest),
      .retire_phys_dest      (retire_phys_dest),
      .rrat_entries          (rrat_entries),
      .rrat_free_list        (rrat_free_list),
      .free_vector_from_rrat (free_vector_from_rrat),
      .commit_error          (commit_error)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of retires, advance past the edge, then clear inputs.
   task automatic drive_slots(input logic [2:0] v,
                              input logic [4:0] a0, input logic [5:0] p0,
                              input logic [4:0] a1, input logic [5:0] p1,
                              input logic [4:0] a2, input logic [5:0] p2);
      retire_valid        = v;
      retire_arch_dest[0] = a0; retire_phys_dest[0] = p0;
      retire_arch_dest[1] = a1; retire_phys_dest[1] = p1;
      retire_arch_dest[2] = a2; retire_phys_dest[2] = p2;
      @(posedge clock);
      #1;
      retire_valid     = '0;
      retire_arch_dest = '0;
      retire_phys_dest = '0;
   endtask

   task automatic idle(input int cycles);
      for (int k = 0; k < cycles; k++) drive_slots(3'b000, 5'd0, 6'd0, 5'd0, 6'd0, 5'd0, 6'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
   endtask

   logic [63:0] all_ones;
   logic [63:0] one;

   initial begin
      checks           = 0;
      failures         = 0;
      reset            = 1'b1;
      retire_valid     = '0;
      retire_arch_dest = '0;
      retire_phys_dest = '0;
      all_ones         = '1;
      one              = 64'd1;

      // Reset then idle
      do_reset();
      idle(3);
      for (int r = 0; r < RAT_SIZE; r++) check($sformatf("rst_map%0d", r), 64'(rrat_entries[r]), 64'd0);
      check("rst_free", rrat_free_list, all_ones);
      check("rst_fv", free_vector_from_rrat, 64'd0);
      check("rst_err", 64'(commit_error), 64'd0);

      // r3 -> p10 (old mapping 0, nothing released)
      drive_slots(3'b001, 5'd3, 6'd10, 5'd0, 6'd0, 5'd0, 6'd0);
      check("a_map3", 64'(rrat_entries[3]), 64'd10);
      check("a_free", rrat_free_list, ~(one << 10));
      check("a_fv", free_vector_from_rrat, 64'd0);

      // r3 -> p12 releases p10
      drive_slots(3'b001, 5'd3, 6'd12, 5'd0, 6'd0, 5'd0, 6'd0);
      check("b_map3", 64'(rrat_entries[3]), 64'd12);
      check("b_fv", free_vector_from_rrat, one << 10);
      check("b_free", rrat_free_list, ~(one << 12));

      // r5 -> p7 as setup
      drive_slots(3'b001, 5'd5, 6'd7, 5'd0, 6'd0, 5'd0, 6'd0);
      check("c_free", rrat_free_list, ~((one << 12) | (one << 7)));

      // same cycle: slot0 r5->p20, slot1 r5->p21
      drive_slots(3'b011, 5'd5, 6'd20, 5'd5, 6'd21, 5'd0, 6'd0);
      check("d_map5", 64'(rrat_entries[5]), 64'd21);
      check("d_fv", free_vector_from_rrat, (one << 7) | (one << 20));
      check("d_free", rrat_free_list, ~((one << 12) | (one << 21)));
      check("d_err", 64'(commit_error), 64'd0);

      // arch 0 slot and invalid slot change nothing
      drive_slots(3'b001, 5'd0, 6'd30, 5'd6, 6'd31, 5'd0, 6'd0);
      check("e_free", rrat_free_list, ~((one << 12) | (one << 21)));
      check("e_fv", free_vector_from_rrat, 64'd0);
      check("e_map0", 64'(rrat_entries[0]), 64'd0);
      check("e_map6", 64'(rrat_entries[6]), 64'd0);
      check("e_map3", 64'(rrat_entries[3]), 64'd12);

      // release and reuse in one cycle: r8->p40, r8->p41 (frees p40), r9->p40
      drive_slots(3'b111, 5'd8, 6'd40, 5'd8, 6'd41, 5'd9, 6'd40);
      check("f_map8", 64'(rrat_entries[8]), 64'd41);
      check("f_map9", 64'(rrat_entries[9]), 64'd40);
      check("f_fv", free_vector_from_rrat, 64'd0);
      check("f_free", rrat_free_list, ~((one << 12) | (one << 21) | (one << 40) | (one << 41)));
      check("f_err", 64'(commit_error), 64'd0);

      // double commit across cycles: r1->p15 then r2->p15
      drive_slots(3'b001, 5'd1, 6'd15, 5'd0, 6'd0, 5'd0, 6'd0);
      check("g_err0", 64'(commit_error), 64'd0);
      drive_slots(3'b001, 5'd2, 6'd15, 5'd0, 6'd0, 5'd0, 6'd0);
      check("g_err1", 64'(commit_error), 64'd1);
      check("g_map2", 64'(rrat_entries[2]), 64'd15);
      idle(3);
      check("g_err_hold", 64'(commit_error), 64'd1);
      check("g_fv_idle", free_vector_from_rrat, 64'd0);

      // reset clears sticky error; then same-cycle double claim of p5
      do_reset();
      check("h_err_rst", 64'(commit_error), 64'd0);
      drive_slots(3'b011, 5'd1, 6'd5, 5'd2, 6'd5, 5'd0, 6'd0);
      check("h_err", 64'(commit_error), 64'd1);
      check("h_map2", 64'(rrat_entries[2]), 64'd5);

      // reset concurrent with retire r4->p9: reset wins
      reset = 1'b1;
      drive_slots(3'b001, 5'd4, 6'd9, 5'd0, 6'd0, 5'd0, 6'd0);
      reset = 1'b0;
      check("i_map4", 64'(rrat_entries[4]), 64'd0);
      check("i_free", rrat_free_list, all_ones);
      check("i_fv", free_vector_from_rrat, 64'd0);
      check("i_err", 64'(commit_error), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
